// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN feature reader.
// Latency: n/a (declarations only).
// Backpressure: n/a. The CHKSUM state exists only when CNN_FEAT_CHECKSUM_EN is defined.
package cnn_pkg;

`ifdef CNN_FEAT_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHKSUM  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_e;
`endif

    // The header word is split into two equal fields:
    // image size in the upper half and the payload word count in the lower half.
    localparam int HDR_NUM_FIELDS = 2;
    localparam int HDR_WORDS_LSB  = 0;

    function automatic int hdr_field_w(input int data_width);
        return data_width / HDR_NUM_FIELDS;
    endfunction

    // Number of payload words needed to carry the feature vector.
    function automatic int calc_words(input int num_features, input int data_width);
        return (num_features + data_width - 1) / data_width;
    endfunction

endpackage

// File: rtl/cnn_feature_reader.sv
// Serialises a captured CNN feature vector into a header word plus ceil(NUM_FEATURES/DATA_WIDTH) payload words.
// Latency: out_valid_o rises one cycle after features_valid_i is accepted; one word per handshake after that.
// Backpressure: valid/ready. Outputs hold while stalled; features_valid_i during a frame is dropped and counted.
// Optional macro CNN_FEAT_CHECKSUM_EN appends an XOR-of-payload word, which then carries out_last_o.
// Ports: wb_clk_i/wb_rst_i (sync, active high); features_valid_i, extracted_features_in, image_size_in in;
//        out_data_o/out_valid_o/out_ready_i/out_last_o stream; frame_done_o, busy_o, drop_count_o status.
module cnn_feature_reader
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int NUM_FEATURES        = 1280,
    parameter int MAX_IMAGE_SIZE_LOG2 = 9
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           features_valid_i,
    input  logic [NUM_FEATURES-1:0]        extracted_features_in,
    input  logic [MAX_IMAGE_SIZE_LOG2:0]   image_size_in,
    output logic [DATA_WIDTH-1:0]          out_data_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic                           out_last_o,
    output logic                           frame_done_o,
    output logic                           busy_o,
    output logic [7:0]                     drop_count_o
);

    localparam int WORDS  = calc_words(NUM_FEATURES, DATA_WIDTH);
    localparam int CAP_W  = WORDS * DATA_WIDTH;
    localparam int HDR_W  = hdr_field_w(DATA_WIDTH);
    localparam int SIZE_W = MAX_IMAGE_SIZE_LOG2 + 1;
    localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);
`ifdef CNN_FEAT_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CAP_W-1:0]        shift_q, shift_d;
    logic [DATA_WIDTH-1:0]   csum_q, csum_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_last_q, out_last_d;
    logic                    frame_done_q, frame_done_d;
    logic [7:0]              drop_q, drop_d;

    logic                    hs;
    logic                    final_hs;
    logic                    accept;
    logic                    drop;
    logic [CAP_W-1:0]        cap_in;
    logic [DATA_WIDTH-1:0]   hdr_word;
    logic [DATA_WIDTH-1:0]   next_word;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        csum_d       = csum_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        drop_d       = drop_q;

        hs       = out_valid_q & out_ready_i;
        final_hs = hs & out_last_q;
        // A new vector arriving on the final handshake starts the next frame back to back.
        accept   = features_valid_i & ((state_q == ST_IDLE) | final_hs);
        drop     = features_valid_i & (state_q != ST_IDLE) & ~final_hs;

        cap_in                      = '0;
        cap_in[NUM_FEATURES-1:0]    = extracted_features_in;
        hdr_word                    = '0;
        hdr_word[HDR_W +: SIZE_W]   = image_size_in;
        hdr_word[HDR_WORDS_LSB +: HDR_W] = HDR_W'(WORDS);
        next_word                   = shift_q[DATA_WIDTH-1:0];

        // Words are preloaded into the output register on the handshake of the
        // previous word, so the checksum already covers every loaded word.
        case (state_q)
            ST_HEADER: begin
                if (hs) begin
                    state_d    = ST_PAYLOAD;
                    cnt_d      = '0;
                    out_data_d = next_word;
                    out_last_d = (WORDS == 1) && !CHK_EN;
                    shift_d    = shift_q >> DATA_WIDTH;
                    csum_d     = csum_q ^ next_word;
                end
            end
            ST_PAYLOAD: begin
                if (hs) begin
                    if (cnt_q == LAST_IDX) begin
`ifdef CNN_FEAT_CHECKSUM_EN
                        state_d    = ST_CHKSUM;
                        out_data_d = csum_q;
                        out_last_d = 1'b1;
`endif
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        out_data_d = next_word;
                        out_last_d = ((cnt_q + 1'b1) == LAST_IDX) && !CHK_EN;
                        shift_d    = shift_q >> DATA_WIDTH;
                        csum_d     = csum_q ^ next_word;
                    end
                end
            end
            default: ;
        endcase

        if (final_hs) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
            out_valid_d  = 1'b0;
            out_data_d   = '0;
            out_last_d   = 1'b0;
            cnt_d        = '0;
        end

        if (accept) begin
            state_d     = ST_HEADER;
            out_valid_d = 1'b1;
            out_data_d  = hdr_word;
            out_last_d  = 1'b0;
            shift_d     = cap_in;
            csum_d      = '0;
            cnt_d       = '0;
        end

        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            csum_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            csum_q       <= csum_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            drop_q       <= drop_d;
        end
    end

    // Capture/shift register holds no control state, so it is left out of reset.
    always_ff @(posedge wb_clk_i) begin
        shift_q <= shift_d;
    end

    assign out_data_o   = out_data_q;
    assign out_valid_o  = out_valid_q;
    assign out_last_o   = out_last_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_cnn_feature_reader.sv
module tb_cnn_feature_reader;

    localparam int DW    = 32;
    localparam int NF    = 1280;
    localparam int MS    = 9;
    localparam int SW    = MS + 1;
    localparam int WORDS = (NF + DW - 1) / DW;
    localparam int RW    = ((NF + 31) / 32) * 32;

    logic             wb_clk_i;
    logic             wb_rst_i;
    logic             features_valid_i;
    logic [NF-1:0]    extracted_features_in;
    logic [SW-1:0]    image_size_in;
    logic [DW-1:0]    out_data_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             out_last_o;
    logic             frame_done_o;
    logic             busy_o;
    logic [7:0]       drop_count_o;

    cnn_feature_reader #(
        .DATA_WIDTH(DW),
        .NUM_FEATURES(NF),
        .MAX_IMAGE_SIZE_LOG2(MS)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .wb_rst_i(wb_rst_i),
        .features_valid_i(features_valid_i),
        .extracted_features_in(extracted_features_in),
        .image_size_in(image_size_in),
        .out_data_o(out_data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_last_o(out_last_o),
        .frame_done_o(frame_done_o),
        .busy_o(busy_o),
        .drop_count_o(drop_count_o)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            hs_count = 0;
    int            ready_mode = 0;
    int            exp_drops = 0;
    logic          done_pending = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready pattern generator: 0 = always high, 1 = toggle, 2 = random, other = held low.
    always @(posedge wb_clk_i) begin
        #1;
        case (ready_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = ~out_ready_i;
            2:       out_ready_i = 1'($urandom_range(0, 1));
            default: out_ready_i = 1'b0;
        endcase
    end

    // Monitor: pops the scoreboard on every handshake and checks protocol rules.
    always @(negedge wb_clk_i) begin
        exp_t e;
        if (wb_rst_i) begin
            done_pending = 1'b0;
            prev_stall   = 1'b0;
        end else begin
            check("frame_done", 64'(frame_done_o), 64'(done_pending));
            check("busy_tracks_valid", 64'(busy_o), 64'(out_valid_o));
            if (!out_valid_o)
                check("idle_data_zero", 64'(out_data_o), 64'd0);
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid_o), 64'd1);
                check("stall_data", 64'(out_data_o), 64'(prev_data));
                check("stall_last", 64'(out_last_o), 64'(prev_last));
            end
            done_pending = 1'b0;
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word at %0t", out_data_o, $time);
                end else begin
                    e = sb.pop_front();
                    check("word_data", 64'(out_data_o), 64'(e.data));
                    check("word_last", 64'(out_last_o), 64'(e.last));
                end
                hs_count++;
                done_pending = out_last_o;
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_data  = out_data_o;
            prev_last  = out_last_o;
        end
    end

    function automatic logic [NF-1:0] rand_feat();
        logic [RW-1:0] w;
        for (int k = 0; k < RW / 32; k++)
            w[k*32 +: 32] = $urandom;
        return w[NF-1:0];
    endfunction

    function automatic logic [DW-1:0] model_header(input logic [SW-1:0] sz);
        return (DW'(sz) << (DW / 2)) | DW'(WORDS);
    endfunction

    // Reference model: header, then the zero-padded vector sliced into words.
    task automatic push_frame(input logic [NF-1:0] f, input logic [SW-1:0] sz);
        logic [WORDS*DW-1:0] padded;
        logic [DW-1:0]       x;
        exp_t                e;
        padded         = '0;
        padded[NF-1:0] = f;
        x              = '0;
        e.data = model_header(sz);
        e.last = 1'b0;
        sb.push_back(e);
        for (int k = 0; k < WORDS; k++) begin
            e.data = padded[k*DW +: DW];
            x      = x ^ e.data;
`ifdef CNN_FEAT_CHECKSUM_EN
            e.last = 1'b0;
`else
            e.last = (k == WORDS - 1);
`endif
            sb.push_back(e);
        end
`ifdef CNN_FEAT_CHECKSUM_EN
        e.data = x;
        e.last = 1'b1;
        sb.push_back(e);
`endif
    endtask

    task automatic bump_drop();
        exp_drops = (exp_drops >= 255) ? 255 : exp_drops + 1;
    endtask

    task automatic send_frame(input logic [NF-1:0] f, input logic [SW-1:0] sz);
        @(posedge wb_clk_i); #2;
        features_valid_i      = 1'b1;
        extracted_features_in = f;
        image_size_in         = sz;
        push_frame(f, sz);
        hs_count = 0;
        @(posedge wb_clk_i); #2;
        features_valid_i      = 1'b0;
        extracted_features_in = rand_feat();
        image_size_in         = SW'($urandom);
        check("latency_valid", 64'(out_valid_o), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy_o) && n < 5000) begin
            @(posedge wb_clk_i); #2;
            n++;
        end
        if (n >= 5000) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got %0d words pending expected 0", name, sb.size());
            sb.delete();
        end
        @(posedge wb_clk_i); #2;
        @(posedge wb_clk_i); #2;
    endtask

    initial begin
        logic [NF-1:0] f;
        int            n;

        wb_rst_i              = 1'b1;
        features_valid_i      = 1'b0;
        extracted_features_in = '0;
        image_size_in         = '0;
        out_ready_i           = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #2;
        wb_rst_i = 1'b0;
        check("rst_valid", 64'(out_valid_o), 64'd0);
        check("rst_data", 64'(out_data_o), 64'd0);
        check("rst_last", 64'(out_last_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(frame_done_o), 64'd0);
        check("rst_drops", 64'(drop_count_o), 64'd0);

        // Word-index pattern, ready high, image size 224.
        ready_mode = 0;
        for (int k = 0; k < WORDS; k++)
            f[k*DW +: DW] = DW'(k);
        send_frame(f, SW'(224));
        check("header_224", 64'(out_data_o), 64'h00E00028);
        wait_idle("index_frame");

        // Ready toggling.
        ready_mode = 1;
        send_frame(rand_feat(), SW'($urandom));
        wait_idle("toggle_frame");

        // Three dropped pulses mid-frame.
        ready_mode = 0;
        @(posedge wb_clk_i); #2;
        send_frame(rand_feat(), SW'($urandom));
        repeat (3) begin
            @(posedge wb_clk_i); #2;
            features_valid_i      = 1'b1;
            extracted_features_in = rand_feat();
            bump_drop();
            @(posedge wb_clk_i); #2;
            features_valid_i = 1'b0;
        end
        wait_idle("drop3_frame");
        check("drop_count_3", 64'(drop_count_o), 64'(exp_drops));

        // Back-to-back frame on the final handshake.
        send_frame(rand_feat(), SW'($urandom));
        n = 0;
        while (!(out_valid_o && out_last_o && out_ready_i) && n < 200) begin
            @(posedge wb_clk_i); #2;
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("FAIL b2b_last_timeout: got no last word expected one");
        end
        f = rand_feat();
        features_valid_i      = 1'b1;
        extracted_features_in = f;
        image_size_in         = SW'(77);
        push_frame(f, SW'(77));
        @(posedge wb_clk_i); #2;
        features_valid_i = 1'b0;
        check("b2b_header_valid", 64'(out_valid_o), 64'd1);
        check("b2b_header_data", 64'(out_data_o), 64'(model_header(SW'(77))));
        check("b2b_header_last", 64'(out_last_o), 64'd0);
        wait_idle("b2b_frame");
        check("b2b_no_drop", 64'(drop_count_o), 64'(exp_drops));

        // Saturating drop counter under a stalled frame.
        ready_mode = 3;
        @(posedge wb_clk_i); #2;
        send_frame(rand_feat(), SW'($urandom));
        repeat (300) begin
            features_valid_i = 1'b1;
            bump_drop();
            @(posedge wb_clk_i); #2;
            features_valid_i = 1'b0;
            @(posedge wb_clk_i); #2;
        end
        check("drop_saturate", 64'(drop_count_o), 64'(exp_drops));
        ready_mode = 0;
        wait_idle("sat_frame");

        // Reset while word 20 is presented.
        send_frame(rand_feat(), SW'($urandom));
        n = 0;
        while (hs_count < 21 && n < 200) begin
            @(posedge wb_clk_i); #2;
            n++;
        end
        check("word20_reached", 64'(hs_count), 64'd21);
        wb_rst_i         = 1'b1;
        features_valid_i = 1'b1;
        sb.delete();
        @(posedge wb_clk_i); #2;
        wb_rst_i         = 1'b0;
        features_valid_i = 1'b0;
        exp_drops        = 0;
        check("midrst_valid", 64'(out_valid_o), 64'd0);
        check("midrst_data", 64'(out_data_o), 64'd0);
        check("midrst_last", 64'(out_last_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_done", 64'(frame_done_o), 64'd0);
        check("midrst_drops", 64'(drop_count_o), 64'd0);
        @(posedge wb_clk_i); #2;
        check("midrst_fv_ignored", 64'(out_valid_o), 64'd0);
        send_frame(rand_feat(), SW'($urandom));
        wait_idle("post_reset_frame");

        // Random frames under random backpressure.
        ready_mode = 2;
        repeat (6) begin
            send_frame(rand_feat(), SW'($urandom));
            wait_idle("random_frame");
        end

`ifdef CNN_FEAT_CHECKSUM_EN
        ready_mode = 0;
        @(posedge wb_clk_i); #2;
        send_frame('1, SW'(224));
        wait_idle("checksum_frame");
`endif

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cnn_feature_reader.md
CNN_FEATURE_READER -- requirements
Module: cnn_feature_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, output word width.
REQ-002 SHALL have parameter NUM_FEATURES, default 1280, width of the feature vector read from the CNN.
REQ-003 SHALL have parameter MAX_IMAGE_SIZE_LOG2, default 9; image size field is MAX_IMAGE_SIZE_LOG2+1 bits.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports wb_clk_i and wb_rst_i.
REQ-005 Ports:
  - wb_clk_i  in  1  clock.
  - wb_rst_i  in  1  synchronous active-high reset.
  - features_valid_i  in  1  one-cycle pulse: CNN feature vector ready.
  - extracted_features_in  in  NUM_FEATURES  CNN feature vector.
  - image_size_in  in  MAX_IMAGE_SIZE_LOG2+1  size of the frame that produced the features.
  - out_data_o  out  DATA_WIDTH  stream word.
  - out_valid_o  out  1  stream valid.
  - out_ready_i  in  1  stream ready.
  - out_last_o  out  1  final word of frame.
  - frame_done_o  out  1  one-cycle pulse on final handshake.
  - busy_o  out  1  frame in progress.
  - drop_count_o  out  8  feature vectors dropped while busy.

Function
REQ-006 WORDS = ceil(NUM_FEATURES/DATA_WIDTH) (40 at defaults); the upper bits of the last payload word are zero-padded.
REQ-007 A frame is one header word followed by WORDS payload words.
  - Header: {zero-extended image_size_in to DATA_WIDTH/2, WORDS as DATA_WIDTH/2 bits}.
  - Payload word k = captured bits [k*DATA_WIDTH +: DATA_WIDTH], k = 0 first.
REQ-008 FSM states: IDLE, HEADER, PAYLOAD, plus CHKSUM when REQ-018 is enabled.
  - IDLE -> HEADER on features_valid_i.
  - HEADER -> PAYLOAD on handshake.
  - PAYLOAD -> IDLE (or CHKSUM) on handshake of word WORDS-1.
  - CHKSUM -> IDLE on handshake.
REQ-009 On acceptance, extracted_features_in and image_size_in SHALL be captured into internal registers; later input changes do not affect the frame.
REQ-010 out_valid_o SHALL rise the cycle after acceptance (latency 1).
REQ-011 Handshake = out_valid_o & out_ready_i. While valid is high and ready is low, out_data_o and out_last_o SHALL hold stable and valid SHALL NOT drop.
REQ-012 Exactly one word SHALL advance per handshake, with no bubbles while out_ready_i stays high.
REQ-013 out_last_o SHALL be high only with the final word of the frame.
REQ-014 frame_done_o SHALL pulse for one cycle, registered, in the cycle after the final handshake.
REQ-015 busy_o SHALL be high from the cycle after acceptance until the final handshake cycle, inclusive.
REQ-016 features_valid_i while busy SHALL be dropped, and drop_count_o SHALL increment, saturating at 255.
  - Exception: features_valid_i coincident with the final handshake SHALL be accepted, giving a back-to-back frame with HEADER valid on the next cycle and no drop counted.
REQ-017 out_data_o SHALL be 0 whenever out_valid_o is low.

Configuration
REQ-018 Macro CNN_FEAT_CHECKSUM_EN:
  - When defined: a trailing word equal to the XOR of all WORDS payload words is sent in state CHKSUM, and out_last_o moves to that word.
  - When undefined: there is no CHKSUM state and the last payload word carries out_last_o.

Reset
REQ-019 Reset SHALL force:
  - state IDLE;
  - out_valid_o, out_last_o, frame_done_o and busy_o to 0;
  - out_data_o to 0;
  - drop_count_o to 0;
  - word counter and checksum accumulator to 0.
REQ-020 Reset mid-frame SHALL abort the frame with no frame_done_o pulse. The capture register need not be cleared.
REQ-021 features_valid_i in a reset cycle SHALL be ignored.

Structure
REQ-022 Shared package cnn_pkg SHALL hold:
  - the FSM state enum;
  - a function computing WORDS;
  - the header field-width constants.
REQ-023 No sub-module is required. The capture/shift register and word counter are inline.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  - Defaults, ready held high, features = word index pattern (word k = k), image_size = 224 -> header 0x00E00028, then 40 words 0..39, last on word 39, frame_done 1 cycle later.
  - Ready toggled 1-0-1-0 -> every word appears exactly once and data is stable while stalled.
  - features_valid_i pulsed 3 times mid-frame -> drop_count_o = 3 and the frame is unaffected. With 300 pulses -> saturates at 255.
  - features_valid_i on the final handshake -> second header on the next cycle, no drop counted.
  - Reset asserted at word 20 -> outputs 0 next cycle, no frame_done, a new frame starts cleanly.
  - With CNN_FEAT_CHECKSUM_EN and all payload words 0xFFFFFFFF -> checksum word 0x00000000 carrying last.
